// File: rtl/wb_port_master.sv
// Single-outstanding pipelined Wishbone master: turns sequencer commands into one
// bus transaction each, with a per-transaction ACK timeout and completion counters.
module wb_port_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [7:0]  ADDR_O,
  output logic [31:0] DATA_O,
  output logic [3:0]  SEL_O,
  input  logic        STALL_I,
  input  logic        ACK_I,
  input  logic [31:0] DATA_I,
  output logic [15:0] ack_count,
  output logic [15:0] err_count
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_tmo;
  logic [15:0] r_ackCnt;
  logic [15:0] r_errCnt;

  logic        w_accept;
  logic        w_busy;
  logic        w_ackDone;
  logic        w_timeout;
  logic [7:0]  w_tmoNext;

  assign w_busy    = (r_state == REQ) || (r_state == WAIT);
  assign w_accept  = (r_state == IDLE) && cmd_valid;
  assign w_tmoNext = r_tmo + 8'd1;
  assign w_ackDone = (r_state == WAIT) && ACK_I;
  // The timeout fires in the cycle the counter would reach the limit, so a
  // transaction gets exactly TIMEOUT cycles in REQ/WAIT; an ACK that same cycle wins.
  assign w_timeout = w_busy && !w_ackDone && (w_tmoNext == TMO_LIMIT);

  always_comb begin
    w_stateNext = r_state;
    cmd_ready   = 1'b0;
    CYC_O       = 1'b0;
    STB_O       = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_stateNext = REQ;
      end
      REQ: begin
        CYC_O = 1'b1;
        STB_O = 1'b1;
        if (w_timeout)     w_stateNext = RESP;
        else if (!STALL_I) w_stateNext = WAIT;
      end
      WAIT: begin
        CYC_O = 1'b1;
        if (w_ackDone || w_timeout) w_stateNext = RESP;
      end
      RESP: begin
        rsp_valid   = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_sel    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_tmo    <= '0;
      r_ackCnt <= '0;
      r_errCnt <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_we    <= cmd_we;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        r_sel   <= cmd_sel;
        r_tmo   <= '0;
      end else if (w_busy) begin
        r_tmo <= w_tmoNext;
      end
      // Write completions report zero data so a stale read value never leaks out.
      if (w_ackDone) begin
        r_rdata <= r_we ? 32'd0 : DATA_I;
        r_err   <= 1'b0;
        if (r_ackCnt != 16'hFFFF) r_ackCnt <= r_ackCnt + 16'd1;
      end else if (w_timeout) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b1;
        if (r_errCnt != 16'hFFFF) r_errCnt <= r_errCnt + 16'd1;
      end
    end
  end

  assign WE_O      = r_we;
  assign ADDR_O    = r_addr;
  assign DATA_O    = r_wdata;
  assign SEL_O     = r_sel;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign ack_count = r_ackCnt;
  assign err_count = r_errCnt;

endmodule

// File: tb/tb_wb_port_master.sv
// Directed bench for wb_port_master: a small byte-select memory acts as the slave,
// transactions come from a vector table, and reset/back-to-back cases are hand-written.
module tb_wb_port_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        CYC_O, STB_O, WE_O;
  logic [7:0]  ADDR_O;
  logic [31:0] DATA_O;
  logic [3:0]  SEL_O;
  logic        STALL_I, ACK_I;
  logic [31:0] DATA_I;
  logic [15:0] ack_count, err_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [256];

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          stall;
    logic        ack;
    logic        spurious;
    logic [31:0] expRdata;
    logic        expErrFlag;
    logic [15:0] expAck;
    logic [15:0] expErrCnt;
    int          expLat;
    int          expCyc;
    int          expStb;
  } vec_t;

  vec_t vecs[9];

  wb_port_master #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADDR_O(ADDR_O), .DATA_O(DATA_O), .SEL_O(SEL_O),
    .STALL_I(STALL_I), .ACK_I(ACK_I), .DATA_I(DATA_I),
    .ack_count(ack_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mkVec(logic we, logic [7:0] addr, logic [31:0] wdata,
                                 logic [3:0] sel, int stall, logic ack, logic spurious,
                                 logic [31:0] expRdata, logic expErrFlag,
                                 logic [15:0] expAck, logic [15:0] expErrCnt,
                                 int expLat, int expCyc, int expStb);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel;
    v.stall = stall; v.ack = ack; v.spurious = spurious;
    v.expRdata = expRdata; v.expErrFlag = expErrFlag;
    v.expAck = expAck; v.expErrCnt = expErrCnt;
    v.expLat = expLat; v.expCyc = expCyc; v.expStb = expStb;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic slaveWrite();
    for (int b = 0; b < 4; b++)
      if (SEL_O[b]) mem[ADDR_O][8*b +: 8] = DATA_O[8*b +: 8];
  endtask

  // Issues one command and plays the slave until rsp_valid, then checks the response.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   cyc, stallLeft, latency, cycCnt, stbCnt;
    logic done, fieldBad;
    cycCnt = 0; stbCnt = 0; latency = -1; done = 1'b0; fieldBad = 1'b0;
    stallLeft = v.stall;
    @(negedge clk);
    checkOutput({tag, ".cmdReadyIdle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_sel = v.sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = 32'h0BAD_F00D;
    cyc = 1;
    while (!done && cyc < 64) begin
      if (rsp_valid) begin
        latency = cyc;
        done = 1'b1;
      end else begin
        if (CYC_O) begin
          cycCnt++;
          if (WE_O !== v.we || ADDR_O !== v.addr || SEL_O !== v.sel || DATA_O !== v.wdata)
            fieldBad = 1'b1;
        end
        if (STB_O) begin
          stbCnt++;
          ACK_I = v.spurious;
          if (stallLeft > 0) begin
            STALL_I = 1'b1;
            stallLeft--;
          end else begin
            STALL_I = 1'b0;
            if (WE_O) slaveWrite();
          end
        end else if (CYC_O) begin
          STALL_I = 1'b0;
          ACK_I   = v.ack;
          DATA_I  = (v.ack && !v.we) ? mem[v.addr] : 32'hCAFE_F00D;
        end else begin
          STALL_I = 1'b0;
          ACK_I   = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    ACK_I = 1'b0; STALL_I = 1'b0;
    checkOutput({tag, ".rspSeen"}, 32'(done), 32'd1);
    checkOutput({tag, ".rdata"}, rsp_rdata, v.expRdata);
    checkOutput({tag, ".err"}, 32'(rsp_err), 32'(v.expErrFlag));
    checkOutput({tag, ".ackCount"}, 32'(ack_count), 32'(v.expAck));
    checkOutput({tag, ".errCount"}, 32'(err_count), 32'(v.expErrCnt));
    checkOutput({tag, ".latency"}, 32'(latency), 32'(v.expLat));
    checkOutput({tag, ".cycCycles"}, 32'(cycCnt), 32'(v.expCyc));
    checkOutput({tag, ".stbCycles"}, 32'(stbCnt), 32'(v.expStb));
    checkOutput({tag, ".fieldsStable"}, 32'(fieldBad), 32'd0);
    @(negedge clk);
    checkOutput({tag, ".rspPulse"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, ".cmdReadyAfter"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, ".rdataHeld"}, rsp_rdata, v.expRdata);
  endtask

  initial begin
    int acc, rsp, cyc;
    int accCyc[3];
    int rspCyc[3];

    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_sel = '0; STALL_I = 1'b0; ACK_I = 1'b0; DATA_I = '0;

    vecs[0] = mkVec(1'b1, 8'h80, 32'hFFFF_0000, 4'hF,  0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 16'd1, 16'd0,  3,  2,  1);
    vecs[1] = mkVec(1'b0, 8'h80, 32'h0000_0000, 4'hF,  0, 1'b1, 1'b0, 32'hFFFF_0000, 1'b0, 16'd2, 16'd0,  3,  2,  1);
    vecs[2] = mkVec(1'b1, 8'h70, 32'hDEAD_BEEF, 4'hF,  3, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 16'd3, 16'd0,  6,  5,  4);
    vecs[3] = mkVec(1'b0, 8'h70, 32'h0000_0000, 4'hF,  0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 16'd4, 16'd0,  3,  2,  1);
    vecs[4] = mkVec(1'b0, 8'h10, 32'h0000_0000, 4'hF,  0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 16'd4, 16'd1, 17, 16,  1);
    vecs[5] = mkVec(1'b0, 8'h70, 32'h0000_0000, 4'h3, 14, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 16'd5, 16'd1, 17, 16, 15);
    vecs[6] = mkVec(1'b1, 8'h22, 32'hA5A5_A5A5, 4'hF, 20, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 16'd5, 16'd2, 17, 16, 16);
    vecs[7] = mkVec(1'b1, 8'h33, 32'h1234_5678, 4'hC,  1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 16'd6, 16'd2,  4,  3,  2);
    vecs[8] = mkVec(1'b0, 8'h33, 32'h0000_0000, 4'hF,  0, 1'b1, 1'b0, 32'h1234_0000, 1'b0, 16'd7, 16'd2,  3,  2,  1);

    // Reset with a command pending: nothing may be accepted and all outputs clear.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h55; cmd_wdata = 32'h1111_2222; cmd_sel = 4'hF;
    repeat (3) @(negedge clk);
    checkOutput("reset.cycDuringRst", 32'(CYC_O), 32'd0);
    checkOutput("reset.stb", 32'(STB_O), 32'd0);
    checkOutput("reset.we", 32'(WE_O), 32'd0);
    checkOutput("reset.addr", 32'(ADDR_O), 32'd0);
    checkOutput("reset.data", DATA_O, 32'd0);
    checkOutput("reset.sel", 32'(SEL_O), 32'd0);
    checkOutput("reset.rspValid", 32'(rsp_valid), 32'd0);
    checkOutput("reset.rspErr", 32'(rsp_err), 32'd0);
    checkOutput("reset.rspRdata", rsp_rdata, 32'd0);
    checkOutput("reset.ackCount", 32'(ack_count), 32'd0);
    checkOutput("reset.errCount", 32'(err_count), 32'd0);
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("reset.idleAfter", 32'(CYC_O), 32'd0);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset while the strobe is stalled: transaction abandoned, counters cleared.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h50; cmd_wdata = 32'h5050_5050; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("rstReq.inReq", 32'(STB_O), 32'd1);
    STALL_I = 1'b1; rst = 1'b1;
    @(negedge clk);
    checkOutput("rstReq.cyc", 32'(CYC_O), 32'd0);
    checkOutput("rstReq.stb", 32'(STB_O), 32'd0);
    checkOutput("rstReq.rspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstReq.ackCount", 32'(ack_count), 32'd0);
    checkOutput("rstReq.errCount", 32'(err_count), 32'd0);
    rst = 1'b0; STALL_I = 1'b0;
    @(negedge clk);
    checkOutput("rstReq.noRsp", 32'(rsp_valid), 32'd0);

    // Reset in WAIT with ACK arriving on the reset edge: reset wins.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h44; cmd_wdata = 32'h4444_4444; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstWait.inWaitCyc", 32'(CYC_O), 32'd1);
    checkOutput("rstWait.inWaitStb", 32'(STB_O), 32'd0);
    rst = 1'b1; ACK_I = 1'b1;
    @(negedge clk);
    checkOutput("rstWait.cyc", 32'(CYC_O), 32'd0);
    checkOutput("rstWait.rspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstWait.ackCount", 32'(ack_count), 32'd0);
    checkOutput("rstWait.rspRdata", rsp_rdata, 32'd0);
    rst = 1'b0; ACK_I = 1'b0;
    @(negedge clk);
    checkOutput("rstWait.noRsp", 32'(rsp_valid), 32'd0);
    applyStimulus(mkVec(1'b0, 8'h80, 32'h0, 4'hF, 0, 1'b1, 1'b0, 32'hFFFF_0000, 1'b0,
                        16'd1, 16'd0, 3, 2, 1), "recover");

    // Back-to-back with cmd_valid held: second command waits for cmd_ready.
    acc = 0; rsp = 0; cyc = 0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h85; cmd_wdata = 32'h1234_1234; cmd_sel = 4'hF;
    while (rsp < 2 && cyc < 40) begin
      if (rsp_valid) begin
        rspCyc[rsp] = cyc;
        rsp++;
        checkOutput($sformatf("b2b.rsp%0dErr", rsp), 32'(rsp_err), 32'd0);
        checkOutput($sformatf("b2b.rsp%0dAckCount", rsp), 32'(ack_count), 32'(1 + rsp));
      end
      if (STB_O) begin
        checkOutput($sformatf("b2b.addrCyc%0d", cyc), 32'(ADDR_O), (acc == 1) ? 32'h85 : 32'h89);
        if (WE_O) slaveWrite();
      end
      STALL_I = 1'b0;
      ACK_I   = CYC_O && !STB_O;
      if (cmd_valid && cmd_ready) begin
        accCyc[acc] = cyc;
        acc++;
      end
      @(negedge clk);
      cyc++;
      if (acc == 1) begin
        cmd_addr = 8'h89; cmd_wdata = 32'h9898_9898;
      end else if (acc == 2) begin
        cmd_valid = 1'b0;
      end
    end
    ACK_I = 1'b0; cmd_valid = 1'b0;
    checkOutput("b2b.rspCount", 32'(rsp), 32'd2);
    checkOutput("b2b.accCount", 32'(acc), 32'd2);
    if (acc == 2) checkOutput("b2b.secondAccept", 32'(accCyc[1] - accCyc[0]), 32'd4);
    if (rsp == 2) begin
      checkOutput("b2b.rsp1Cycle", 32'(rspCyc[0]), 32'd3);
      checkOutput("b2b.rsp2Cycle", 32'(rspCyc[1]), 32'd7);
    end
    checkOutput("b2b.mem85", mem[8'h85], 32'h1234_1234);
    checkOutput("b2b.mem89", mem[8'h89], 32'h9898_9898);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
